load_read_unit: RTL and testbench
=================================

LOAD_READ_UNIT -- requirements
Module: load_read_unit

Interface
REQ-001 Parameter TIMEOUT_CYC, default 16, max cycles mem_req may stay high without mem_ack.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 ld_valid  input  1  pipeline presents a load request.
REQ-005 ld_ready  output  1  unit can accept a request.
REQ-006 ld_addr  input  32  byte address of the load.
REQ-007 ld_funct3  input  3  load type: 0 lb, 1 lh, 2 lw, 4 lbu, 5 lhu.
REQ-008 ld_rd  input  5  destination register tag.
REQ-009 mem_req  output  1  read request to data RAM.
REQ-010 mem_addr  output  32  word-aligned RAM address.
REQ-011 mem_ack  input  1  RAM read complete; mem_rdata valid this cycle.
REQ-012 mem_rdata  input  32  RAM read word, little-endian.
REQ-013 wb_valid  output  1  writeback data available.
REQ-014 wb_ready  input  1  register file consumes writeback.
REQ-015 wb_data  output  32  extracted, extended load result.
REQ-016 wb_rd  output  5  destination tag echoed from request.
REQ-017 wb_err  output  1  result is error (misaligned, illegal funct3, timeout); valid with wb_valid.

Function
REQ-018 FSM states IDLE, REQ, DONE; ld_ready SHALL be 1 only in IDLE.
REQ-019 Accept on ld_valid && ld_ready: latch ld_addr, ld_funct3, ld_rd in that cycle.
REQ-020 Accepted request with illegal funct3 (3, 6, 7) or misalignment (lh/lhu addr[0]=1; lw addr[1:0]!=0) SHALL go directly to DONE with wb_data=0, wb_err=1, no mem_req.
REQ-021 Otherwise go to REQ: mem_req=1, mem_addr={addr[31:2],2'b00}, both held stable until mem_ack.
REQ-022 mem_ack SHALL be honoured only in REQ; mem_ack in IDLE or DONE is ignored.
REQ-023 On mem_ack in REQ: capture extracted data, wb_err=0, go to DONE; mem_req SHALL be 0 the following cycle.
REQ-024 Extraction: byte lane addr[1:0], halfword lane addr[1]; lb/lh sign-extend, lbu/lhu zero-extend, lw passes word.
REQ-025 Timeout counter clears on REQ entry, increments each REQ cycle without ack; reaching TIMEOUT_CYC SHALL go to DONE with wb_data=0, wb_err=1, mem_req dropped.
REQ-026 Ack arriving in the same cycle the counter reaches TIMEOUT_CYC SHALL win (normal completion).
REQ-027 DONE: wb_valid=1, wb_data/wb_rd/wb_err stable until wb_ready; on wb_valid && wb_ready go to IDLE.
REQ-028 Latency: accept at cycle 0, mem_req high cycle 1, ack at cycle k, wb_valid high cycle k+1; error bypass wb_valid at cycle 1.
REQ-029 No back-to-back overlap: a new request is accepted no earlier than the cycle after the writeback handshake.

Reset
REQ-030 rst SHALL force IDLE at the next rising edge, including mid-REQ or mid-DONE; pending result discarded.
REQ-031 Reset values: ld_ready=1 (IDLE), mem_req=0, mem_addr=0, wb_valid=0, wb_data=0, wb_rd=0, wb_err=0, timeout counter=0.
REQ-032 A mem_ack for a request aborted by reset SHALL be ignored.

Structure
REQ-033 Shared package SHALL hold funct3 load encodings, FSM state enum, and the 32-bit data width constant.
REQ-034 Lane selection and extension SHALL be a combinational sub-module load_extract (rdata, addr[1:0], funct3 -> data).

Verification
REQ-035 lw addr 0x100, mem_rdata 0xDEADBEEF, ack after 3 cycles -> mem_addr 0x100, wb_data 0xDEADBEEF, wb_err 0, wb_valid cycle 4.
REQ-036 lb addr 0x103 rdata 0x80112233 -> wb_data 0xFFFFFF80; lbu same -> 0x00000080; lhu addr 0x102 -> 0x00008011.
REQ-037 lh addr 0x101 -> no mem_req, wb_valid cycle 1, wb_err 1, wb_data 0.
REQ-038 lw with no ack, TIMEOUT_CYC=16 -> mem_req drops, wb_err 1; late ack then ignored, state IDLE after wb_ready.
REQ-039 wb_ready held 0 for 5 cycles -> wb_valid, wb_data stable, ld_ready 0 throughout.
REQ-040 rst asserted in REQ, ack next cycle -> mem_req 0, ld_ready 1, no wb_valid.

Source files
------------

// File: rtl/load_read_unit_pkg.sv
// Shared definitions for the load read unit: data width, funct3 load encodings,
// FSM states and the request legality check.
package load_read_unit_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        F3_LB  = 3'd0,
        F3_LH  = 3'd1,
        F3_LW  = 3'd2,
        F3_LBU = 3'd4,
        F3_LHU = 3'd5
    } load_f3_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } lru_state_e;

    // True when the request must bypass memory: unknown funct3 or a misaligned access.
    function automatic logic load_is_err(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3)
            F3_LB, F3_LBU: return 1'b0;
            F3_LH, F3_LHU: return addr_lo[0];
            F3_LW:         return addr_lo != 2'b00;
            default:       return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/load_read_unit_if.sv
// Pipeline request, data RAM read and writeback signals of the load read unit.
// Handshakes: a transfer happens on a rising edge where valid && ready (ld_*, wb_*);
// mem_req/mem_addr stay stable until a cycle with mem_ack.
interface load_read_unit_if;
    import load_read_unit_pkg::*;

    logic              ld_valid;
    logic              ld_ready;
    logic [31:0]       ld_addr;
    logic [2:0]        ld_funct3;
    logic [4:0]        ld_rd;
    logic              mem_req;
    logic [31:0]       mem_addr;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic              wb_valid;
    logic              wb_ready;
    logic [DATA_W-1:0] wb_data;
    logic [4:0]        wb_rd;
    logic              wb_err;

    modport master (
        output ld_valid, ld_addr, ld_funct3, ld_rd, mem_ack, mem_rdata, wb_ready,
        input  ld_ready, mem_req, mem_addr, wb_valid, wb_data, wb_rd, wb_err
    );

    modport slave (
        input  ld_valid, ld_addr, ld_funct3, ld_rd, mem_ack, mem_rdata, wb_ready,
        output ld_ready, mem_req, mem_addr, wb_valid, wb_data, wb_rd, wb_err
    );

endinterface

// File: rtl/load_read_unit_extract.sv
// Combinational lane selection and sign/zero extension of a little-endian RAM word.
module load_extract
    import load_read_unit_pkg::*;
(
    input  logic [DATA_W-1:0] rdata_i,
    input  logic [1:0]        addr_i,
    input  logic [2:0]        funct3_i,
    output logic [DATA_W-1:0] data_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = 8'd0;
        case (addr_i)
            2'd0: byte_v = rdata_i[7:0];
            2'd1: byte_v = rdata_i[15:8];
            2'd2: byte_v = rdata_i[23:16];
            2'd3: byte_v = rdata_i[31:24];
            default: byte_v = 8'd0;
        endcase
        half_v = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        data_o = '0;
        case (funct3_i)
            F3_LB:   data_o = {{24{byte_v[7]}}, byte_v};
            F3_LH:   data_o = {{16{half_v[15]}}, half_v};
            F3_LW:   data_o = rdata_i;
            F3_LBU:  data_o = {24'd0, byte_v};
            F3_LHU:  data_o = {16'd0, half_v};
            default: data_o = '0;
        endcase
    end

endmodule

// File: rtl/load_read_unit.sv
// Single-outstanding load unit: accepts a load, reads one RAM word with a timeout,
// extracts the addressed lane and holds the result until writeback.
module load_read_unit
    import load_read_unit_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic             clk,
    input  logic             rst,
    load_read_unit_if.slave  bus,
    output lru_state_e       dbg_state_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    lru_state_e        state_q;
    logic [1:0]        addr_lo_q;
    logic [2:0]        funct3_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              mem_req_q;
    logic [31:0]       mem_addr_q;
    logic              wb_valid_q;
    logic [DATA_W-1:0] wb_data_q;
    logic [4:0]        wb_rd_q;
    logic              wb_err_q;
    logic [DATA_W-1:0] ext_data_d;

    load_extract u_extract (
        .rdata_i  (bus.mem_rdata),
        .addr_i   (addr_lo_q),
        .funct3_i (funct3_q),
        .data_o   (ext_data_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_lo_q  <= 2'd0;
            funct3_q   <= 3'd0;
            cnt_q      <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= 32'd0;
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            wb_rd_q    <= 5'd0;
            wb_err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.ld_valid) begin
                        addr_lo_q <= bus.ld_addr[1:0];
                        funct3_q  <= bus.ld_funct3;
                        wb_rd_q   <= bus.ld_rd;
                        if (load_is_err(bus.ld_funct3, bus.ld_addr[1:0])) begin
                            state_q    <= ST_DONE;
                            wb_valid_q <= 1'b1;
                            wb_data_q  <= '0;
                            wb_err_q   <= 1'b1;
                        end else begin
                            state_q    <= ST_REQ;
                            mem_req_q  <= 1'b1;
                            mem_addr_q <= {bus.ld_addr[31:2], 2'b00};
                            cnt_q      <= '0;
                        end
                    end
                end
                ST_REQ: begin
                    // An ack in the final allowed cycle still completes normally.
                    if (bus.mem_ack) begin
                        state_q    <= ST_DONE;
                        mem_req_q  <= 1'b0;
                        wb_valid_q <= 1'b1;
                        wb_data_q  <= ext_data_d;
                        wb_err_q   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                            state_q    <= ST_DONE;
                            mem_req_q  <= 1'b0;
                            wb_valid_q <= 1'b1;
                            wb_data_q  <= '0;
                            wb_err_q   <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (bus.wb_ready) begin
                        state_q    <= ST_IDLE;
                        wb_valid_q <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.ld_ready  = (state_q == ST_IDLE);
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.wb_valid  = wb_valid_q;
    assign bus.wb_data   = wb_data_q;
    assign bus.wb_rd     = wb_rd_q;
    assign bus.wb_err    = wb_err_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_load_read_unit.sv
// Directed bench for load_read_unit: loads of every type, error bypass, timeout,
// ack-on-deadline, writeback backpressure, reset abort and stray acks.
module tb_load_read_unit;
    import load_read_unit_pkg::*;

    logic       clk;
    logic       rst;
    lru_state_e dbg_state;
    int         checks;
    int         failures;

    load_read_unit_if bus ();

    load_read_unit #(.TIMEOUT_CYC(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .dbg_state_o (dbg_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic accept(input logic [31:0] addr, input logic [2:0] f3, input logic [4:0] rd);
        bus.ld_valid  = 1'b1;
        bus.ld_addr   = addr;
        bus.ld_funct3 = f3;
        bus.ld_rd     = rd;
        step();
        bus.ld_valid  = 1'b0;
    endtask

    task automatic handshake(input string tag);
        bus.wb_ready = 1'b1;
        step();
        bus.wb_ready = 1'b0;
        chk({tag, "_wbv_after"}, 32'(bus.wb_valid), 32'd0);
        chk({tag, "_ready_after"}, 32'(bus.ld_ready), 32'd1);
        chk({tag, "_state_after"}, 32'(dbg_state), 32'(ST_IDLE));
    endtask

    // Accept at cycle 0, ack in cycle k, expect the result in cycle k+1.
    task automatic run_load(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                            input logic [4:0] rd, input int k, input logic [31:0] rdata,
                            input logic [31:0] exp_data);
        accept(addr, f3, rd);
        for (int i = 1; i <= k; i++) begin
            chk({tag, "_req"}, 32'(bus.mem_req), 32'd1);
            chk({tag, "_maddr"}, bus.mem_addr, {addr[31:2], 2'b00});
            chk({tag, "_wbv_early"}, 32'(bus.wb_valid), 32'd0);
            chk({tag, "_ldrdy_busy"}, 32'(bus.ld_ready), 32'd0);
            if (i == k) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = rdata;
            end
            step();
        end
        bus.mem_ack = 1'b0;
        chk({tag, "_req_drop"}, 32'(bus.mem_req), 32'd0);
        chk({tag, "_wbv"}, 32'(bus.wb_valid), 32'd1);
        chk({tag, "_data"}, bus.wb_data, exp_data);
        chk({tag, "_err"}, 32'(bus.wb_err), 32'd0);
        chk({tag, "_rd"}, 32'(bus.wb_rd), 32'(rd));
        handshake(tag);
    endtask

    task automatic run_err(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                           input logic [4:0] rd);
        accept(addr, f3, rd);
        chk({tag, "_req"}, 32'(bus.mem_req), 32'd0);
        chk({tag, "_wbv"}, 32'(bus.wb_valid), 32'd1);
        chk({tag, "_err"}, 32'(bus.wb_err), 32'd1);
        chk({tag, "_data"}, bus.wb_data, 32'd0);
        chk({tag, "_rd"}, 32'(bus.wb_rd), 32'(rd));
        handshake(tag);
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst           = 1'b1;
        bus.ld_valid  = 1'b0;
        bus.ld_addr   = 32'd0;
        bus.ld_funct3 = 3'd0;
        bus.ld_rd     = 5'd0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'd0;
        bus.wb_ready  = 1'b0;
        step();
        step();
        chk("rst_ldrdy", 32'(bus.ld_ready), 32'd1);
        chk("rst_req", 32'(bus.mem_req), 32'd0);
        chk("rst_maddr", bus.mem_addr, 32'd0);
        chk("rst_wbv", 32'(bus.wb_valid), 32'd0);
        chk("rst_data", bus.wb_data, 32'd0);
        chk("rst_rd", 32'(bus.wb_rd), 32'd0);
        chk("rst_err", 32'(bus.wb_err), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        rst = 1'b0;
        step();

        // Normal loads across every type and lane.
        run_load("lw100",  32'h100, 3'd2, 5'd5,  3, 32'hDEADBEEF, 32'hDEADBEEF);
        run_load("lb103",  32'h103, 3'd0, 5'd1,  1, 32'h80112233, 32'hFFFFFF80);
        run_load("lbu103", 32'h103, 3'd4, 5'd2,  2, 32'h80112233, 32'h00000080);
        run_load("lhu102", 32'h102, 3'd5, 5'd3,  1, 32'h80112233, 32'h00008011);
        run_load("lh102",  32'h102, 3'd1, 5'd4,  1, 32'h80112233, 32'hFFFF8011);
        run_load("lb101",  32'h101, 3'd0, 5'd6,  1, 32'h80112233, 32'h00000022);
        run_load("lh100",  32'h100, 3'd1, 5'd8,  2, 32'h8011F233, 32'hFFFFF233);
        run_load("lbu100", 32'h4,   3'd4, 5'd10, 1, 32'h80112233, 32'h00000033);

        // Error bypass: misalignment and illegal funct3.
        run_err("lh101",  32'h101, 3'd1, 5'd11);
        run_err("lhu103", 32'h103, 3'd5, 5'd12);
        run_err("lw102",  32'h102, 3'd2, 5'd13);
        run_err("f3_3",   32'h100, 3'd3, 5'd14);
        run_err("f3_6",   32'h100, 3'd6, 5'd15);
        run_err("f3_7",   32'h100, 3'd7, 5'd16);

        // Ack in the 16th request cycle beats the timeout.
        run_load("ack_edge", 32'h40, 3'd2, 5'd17, 16, 32'hCAFEF00D, 32'hCAFEF00D);

        // Timeout: mem_req high cycles 1..16, error result in cycle 17.
        accept(32'h200, 3'd2, 5'd9);
        for (int i = 1; i <= 16; i++) begin
            chk("to_req", 32'(bus.mem_req), 32'd1);
            chk("to_wbv_early", 32'(bus.wb_valid), 32'd0);
            step();
        end
        chk("to_req_drop", 32'(bus.mem_req), 32'd0);
        chk("to_wbv", 32'(bus.wb_valid), 32'd1);
        chk("to_err", 32'(bus.wb_err), 32'd1);
        chk("to_data", bus.wb_data, 32'd0);

        // Backpressure with a late ack and a waiting request; neither may disturb the result.
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h12345678;
        bus.ld_valid  = 1'b1;
        bus.ld_addr   = 32'h300;
        bus.ld_funct3 = 3'd2;
        bus.ld_rd     = 5'd7;
        for (int i = 0; i < 5; i++) begin
            step();
            bus.mem_ack = 1'b0;
            chk("bp_wbv", 32'(bus.wb_valid), 32'd1);
            chk("bp_data", bus.wb_data, 32'd0);
            chk("bp_err", 32'(bus.wb_err), 32'd1);
            chk("bp_rd", 32'(bus.wb_rd), 32'd9);
            chk("bp_ldrdy", 32'(bus.ld_ready), 32'd0);
            chk("bp_req", 32'(bus.mem_req), 32'd0);
        end
        bus.wb_ready = 1'b1;
        step();
        bus.wb_ready = 1'b0;
        chk("b2b_ldrdy", 32'(bus.ld_ready), 32'd1);
        chk("b2b_no_req", 32'(bus.mem_req), 32'd0);
        chk("b2b_wbv", 32'(bus.wb_valid), 32'd0);
        step();
        bus.ld_valid = 1'b0;
        chk("b2b_req", 32'(bus.mem_req), 32'd1);
        chk("b2b_maddr", bus.mem_addr, 32'h300);
        bus.mem_ack = 1'b1;
        step();
        bus.mem_ack = 1'b0;
        chk("b2b_data", bus.wb_data, 32'h12345678);
        chk("b2b_rd", 32'(bus.wb_rd), 32'd7);
        chk("b2b_err", 32'(bus.wb_err), 32'd0);
        handshake("b2b");

        // Stray ack while idle.
        bus.mem_ack = 1'b1;
        step();
        bus.mem_ack = 1'b0;
        chk("idle_ack_state", 32'(dbg_state), 32'(ST_IDLE));
        chk("idle_ack_wbv", 32'(bus.wb_valid), 32'd0);
        chk("idle_ack_req", 32'(bus.mem_req), 32'd0);

        // Reset during REQ, then an ack for the aborted request.
        accept(32'h500, 3'd2, 5'd20);
        chk("ra_req_pre", 32'(bus.mem_req), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hA5A5A5A5;
        chk("ra_req", 32'(bus.mem_req), 32'd0);
        chk("ra_maddr", bus.mem_addr, 32'd0);
        chk("ra_ldrdy", 32'(bus.ld_ready), 32'd1);
        chk("ra_wbv", 32'(bus.wb_valid), 32'd0);
        step();
        bus.mem_ack = 1'b0;
        chk("ra_wbv_after", 32'(bus.wb_valid), 32'd0);
        chk("ra_state", 32'(dbg_state), 32'(ST_IDLE));
        chk("ra_data", bus.wb_data, 32'd0);

        // Reset during DONE discards the pending result.
        run_err("pre_rd", 32'h1, 3'd2, 5'd21);
        accept(32'h1, 3'd2, 5'd22);
        chk("rd_wbv_pre", 32'(bus.wb_valid), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rd_wbv", 32'(bus.wb_valid), 32'd0);
        chk("rd_err", 32'(bus.wb_err), 32'd0);
        chk("rd_rd", 32'(bus.wb_rd), 32'd0);
        chk("rd_ldrdy", 32'(bus.ld_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
